// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU mode constants, op-field bit positions and sequencer state encoding.
package alu_muldiv_seq_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0111;
  localparam logic [3:0] ALU_PASS_A = 4'b1110;

  localparam int OP_KIND_BIT   = 0;
  localparam int OP_SIGNED_BIT = 1;

  // Values of op[OP_KIND_BIT]
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/result bundle between the CPU control unit (master) and the mul/div sequencer (slave).
interface alu_muldiv_seq_if;
  logic       start;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] res_hi;
  logic [7:0] res_lo;
  logic       dbz;

  modport master (
    output start, op, a, b,
    input  busy, done, res_hi, res_lo, dbz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, res_hi, res_lo, dbz
  );
endinterface

// File: rtl/alu_muldiv_seq_sign_fix.sv
// Conditional two's-complement negate of a W-bit value; only built with MULDIV_SIGNED_EN.
`ifdef MULDIV_SIGNED_EN
module alu_muldiv_seq_sign_fix #(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? (~val + W'(1)) : val;
endmodule
`endif

// File: rtl/alu_muldiv_seq.sv
// Sequencer running 8x8 shift-add multiply and 8/8 restoring divide on the shared CPU ALU (MULDIV_SIGNED_EN adds signed ops).
// Latency: DONE in cycle 10 after the start edge (2 on divide-by-zero, 12 for signed ops); done is a 1-cycle pulse.
// Backpressure: none queued; start is sampled only while idle and ignored while busy.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int ITERS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_muldiv_seq_if.slave cpu,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [3:0]      alu_mode,
  output logic            alu_cin,
  input  logic [7:0]      alu_out,
  input  logic            alu_cout
);

  localparam int CW = $clog2(ITERS);

  state_t        state;
  logic          busy_q;
  logic          done_q;
  logic          dbz_q;
  logic [7:0]    res_hi_q;
  logic [7:0]    res_lo_q;
  logic          is_div;
  logic [7:0]    src_a;
  logic [7:0]    src_b;
  logic [7:0]    acc;
  logic [7:0]    lo;
  logic [CW-1:0] cnt;

  logic [7:0]    acc_nx;
  logic [7:0]    lo_nx;
  logic [7:0]    r_sh;
  logic          qbit;
  logic          carry;
  logic          last;
  logic [7:0]    dbz_a;

  assign cpu.busy   = busy_q;
  assign cpu.done   = done_q;
  assign cpu.dbz    = dbz_q;
  assign cpu.res_hi = res_hi_q;
  assign cpu.res_lo = res_lo_q;

  assign last = (cnt == CW'(ITERS - 1));

`ifdef MULDIV_SIGNED_EN
  logic        is_sgn;
  logic        neg_a;
  logic        neg_b;
  logic [7:0]  orig_a;
  logic [7:0]  abs_a;
  logic [7:0]  abs_b;
  logic [7:0]  fix_q;
  logic [7:0]  fix_r;
  logic [15:0] fix_p;

  alu_muldiv_seq_sign_fix #(.W(8))  u_abs_a (.val(src_a),     .neg(src_a[7]),     .res(abs_a));
  alu_muldiv_seq_sign_fix #(.W(8))  u_abs_b (.val(src_b),     .neg(src_b[7]),     .res(abs_b));
  alu_muldiv_seq_sign_fix #(.W(16)) u_fix_p (.val({acc, lo}), .neg(neg_a ^ neg_b), .res(fix_p));
  alu_muldiv_seq_sign_fix #(.W(8))  u_fix_q (.val(lo),        .neg(neg_a ^ neg_b), .res(fix_q));
  // Remainder follows the sign of the dividend
  alu_muldiv_seq_sign_fix #(.W(8))  u_fix_r (.val(acc),       .neg(neg_a),         .res(fix_r));

  assign dbz_a = orig_a;
`else
  logic unused_sign;
  assign unused_sign = cpu.op[OP_SIGNED_BIT];
  assign dbz_a       = src_a;
`endif

  // One iteration step from the ALU result: acc is P_hi / R, lo is P_lo / Q
  always_comb begin
    acc_nx = acc;
    lo_nx  = lo;
    r_sh   = {acc[6:0], lo[7]};
    qbit   = 1'b0;
    carry  = 1'b0;
    if (is_div) begin
      qbit   = acc[7] | ~alu_cout;
      acc_nx = qbit ? alu_out : r_sh;
      lo_nx  = {lo[6:0], qbit};
    end else begin
      carry  = lo[0] & alu_cout;
      acc_nx = {carry, alu_out[7:1]};
      lo_nx  = {alu_out[0], lo[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      res_hi_q <= 8'h00;
      res_lo_q <= 8'h00;
      alu_a    <= 8'h00;
      alu_b    <= 8'h00;
      alu_mode <= ALU_PASS_A;
      alu_cin  <= 1'b0;
      is_div   <= 1'b0;
      src_a    <= 8'h00;
      src_b    <= 8'h00;
      acc      <= 8'h00;
      lo       <= 8'h00;
      cnt      <= '0;
`ifdef MULDIV_SIGNED_EN
      is_sgn   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      orig_a   <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu.start) begin
            is_div <= (cpu.op[OP_KIND_BIT] == OP_DIV);
            src_a  <= cpu.a;
            src_b  <= cpu.b;
            dbz_q  <= 1'b0;
            busy_q <= 1'b1;
`ifdef MULDIV_SIGNED_EN
            is_sgn <= cpu.op[OP_SIGNED_BIT];
            orig_a <= cpu.a;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            state  <= cpu.op[OP_SIGNED_BIT] ? S_PRE : S_LOAD;
`else
            state  <= S_LOAD;
`endif
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_PRE: begin
          neg_a <= src_a[7];
          neg_b <= src_b[7];
          src_a <= abs_a;
          src_b <= abs_b;
          state <= S_LOAD;
        end
`endif
        S_LOAD: begin
          acc     <= 8'h00;
          cnt     <= '0;
          alu_cin <= 1'b0;
          if (is_div && (src_b == 8'h00)) begin
            res_lo_q <= 8'hFF;
            res_hi_q <= dbz_a;
            dbz_q    <= 1'b1;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end else if (is_div) begin
            lo       <= src_a;
            alu_a    <= {7'b0, src_a[7]};
            alu_b    <= src_b;
            alu_mode <= ALU_SUB;
            state    <= S_ITER;
          end else begin
            lo       <= src_b;
            alu_a    <= 8'h00;
            alu_b    <= src_a;
            alu_mode <= src_b[0] ? ALU_ADD : ALU_PASS_A;
            state    <= S_ITER;
          end
        end
        S_ITER: begin
          cnt <= cnt + 1'b1;
          acc <= acc_nx;
          lo  <= lo_nx;
          // ALU operands are registered, so set up the next step from the next-state values
          alu_a    <= is_div ? {acc_nx[6:0], lo_nx[7]} : acc_nx;
          alu_mode <= is_div ? ALU_SUB : (lo_nx[0] ? ALU_ADD : ALU_PASS_A);
          if (last) begin
            alu_a    <= 8'h00;
            alu_b    <= 8'h00;
            alu_mode <= ALU_PASS_A;
`ifdef MULDIV_SIGNED_EN
            if (is_sgn) begin
              state <= S_FIX;
            end else begin
              res_hi_q <= acc_nx;
              res_lo_q <= lo_nx;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end
`else
            res_hi_q <= acc_nx;
            res_lo_q <= lo_nx;
            done_q   <= 1'b1;
            state    <= S_DONE;
`endif
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_FIX: begin
          if (is_div) begin
            res_hi_q <= fix_r;
            res_lo_q <= fix_q;
          end else begin
            res_hi_q <= fix_p[15:8];
            res_lo_q <= fix_p[7:0];
          end
          done_q <= 1'b1;
          state  <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ALU and an arithmetic scoreboard.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       dbz;
    int         lat;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_mode;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic       alu_cout;

  int   tests;
  int   fails;
  exp_t sb[$];

  alu_muldiv_seq_if ifc ();

  alu_muldiv_seq #(.ITERS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu      (ifc),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_mode (alu_mode),
    .alu_cin  (alu_cin),
    .alu_out  (alu_out),
    .alu_cout (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared CPU ALU: carry-out on ADD, borrow-out on SUB
  always_comb begin
    {alu_cout, alu_out} = {1'b0, alu_a};
    case (alu_mode)
      4'b0100: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
      4'b0111: {alu_cout, alu_out} = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin};
      default: {alu_cout, alu_out} = {1'b0, alu_a};
    endcase
  end

  function automatic exp_t model(input logic [1:0] o, input logic [7:0] ia, input logic [7:0] ib);
    exp_t        e;
    logic        sgn;
    int          sa;
    int          sb_v;
    logic [31:0] pr;
    logic [31:0] q;
    logic [31:0] r;
    sgn  = SIGNED_BUILD && o[1];
    sa   = sgn ? int'($signed(ia)) : int'(ia);
    sb_v = sgn ? int'($signed(ib)) : int'(ib);
    e.dbz = 1'b0;
    e.lat = sgn ? 12 : 10;
    if (!o[0]) begin
      pr   = 32'(sa * sb_v);
      e.hi = pr[15:8];
      e.lo = pr[7:0];
    end else if (ib == 8'h00) begin
      e.hi  = ia;
      e.lo  = 8'hFF;
      e.dbz = 1'b1;
      e.lat = sgn ? 3 : 2;
    end else begin
      q    = 32'(sa / sb_v);
      r    = 32'(sa % sb_v);
      e.hi = r[7:0];
      e.lo = q[7:0];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".busy"},     {15'b0, ifc.busy},   16'h0);
    chk({tag, ".done"},     {15'b0, ifc.done},   16'h0);
    chk({tag, ".dbz"},      {15'b0, ifc.dbz},    16'h0);
    chk({tag, ".res_hi"},   {8'b0, ifc.res_hi},  16'h0);
    chk({tag, ".res_lo"},   {8'b0, ifc.res_lo},  16'h0);
    chk({tag, ".alu_a"},    {8'b0, alu_a},       16'h0);
    chk({tag, ".alu_b"},    {8'b0, alu_b},       16'h0);
    chk({tag, ".alu_mode"}, {12'b0, alu_mode},   16'h000E);
    chk({tag, ".alu_cin"},  {15'b0, alu_cin},    16'h0);
  endtask

  // Runs one op; a nonzero poke cycle pulses a competing DIV start mid-operation
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] ia,
                       input logic [7:0] ib, input int poke);
    exp_t       e;
    int         lat;
    bit         busy_ok;
    logic       dbz1;
    logic [7:0] hi_d;
    logic [7:0] lo_d;
    logic       dbz_d;
    logic [3:0] mode_d;
    logic [7:0] alua_d;
    sb.push_back(model(o, ia, ib));
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.op    = o;
    ifc.a     = ia;
    ifc.b     = ib;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    lat = 0; busy_ok = 1'b1; dbz1 = ifc.dbz;
    hi_d = 8'hxx; lo_d = 8'hxx; dbz_d = 1'bx; mode_d = 4'hx; alua_d = 8'hxx;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (c == poke) begin
        ifc.start = 1'b1; ifc.op = {1'b0, OP_DIV}; ifc.a = 8'h01; ifc.b = 8'h00;
      end else if (c == poke + 1) begin
        ifc.start = 1'b0;
      end
      if (ifc.busy !== 1'b1) busy_ok = 1'b0;
      if (ifc.done === 1'b1) begin
        lat = c; hi_d = ifc.res_hi; lo_d = ifc.res_lo; dbz_d = ifc.dbz;
        mode_d = alu_mode; alua_d = alu_a;
        break;
      end
    end
    ifc.start = 1'b0;
    e = sb.pop_front();
    chk({tag, ".latency"},   16'(lat),         16'(e.lat));
    chk({tag, ".busy_hold"}, {15'b0, busy_ok}, 16'h1);
    chk({tag, ".dbz_clr"},   {15'b0, dbz1},    16'h0);
    chk({tag, ".res_hi"},    {8'b0, hi_d},     {8'b0, e.hi});
    chk({tag, ".res_lo"},    {8'b0, lo_d},     {8'b0, e.lo});
    chk({tag, ".dbz"},       {15'b0, dbz_d},   {15'b0, e.dbz});
    chk({tag, ".alu_mode"},  {12'b0, mode_d},  16'h000E);
    chk({tag, ".alu_a"},     {8'b0, alua_d},   16'h0);
    @(negedge clk);
    chk({tag, ".busy_off"},  {15'b0, ifc.busy}, 16'h0);
    chk({tag, ".done_off"},  {15'b0, ifc.done}, 16'h0);
    chk({tag, ".res_keep"},  {ifc.res_hi, ifc.res_lo}, {e.hi, e.lo});
  endtask

  initial begin
    bit seen;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ifc.start = 1'b0;
    ifc.op    = 2'b00;
    ifc.a     = 8'h00;
    ifc.b     = 8'h00;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    do_op("mul_13x11", {1'b0, OP_MUL}, 8'd13,  8'd11, 0);
    do_op("mul_ffxff", {1'b0, OP_MUL}, 8'hFF,  8'hFF, 0);
    do_op("div_200_7", {1'b0, OP_DIV}, 8'd200, 8'd7,  0);
    do_op("div_ff_1",  {1'b0, OP_DIV}, 8'hFF,  8'h01, 0);
    do_op("div_by0",   {1'b0, OP_DIV}, 8'h55,  8'h00, 0);
    do_op("mul_after", {1'b0, OP_MUL}, 8'd3,   8'd5,  0);
    do_op("mul_poke",  {1'b0, OP_MUL}, 8'h12,  8'h34, 5);
    do_op("mul_op1",   2'b10,          8'd13,  8'd11, 0);

    // Reset during cycle 6 of a multiply
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = {1'b0, OP_MUL}; ifc.a = 8'h21; ifc.b = 8'h09;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ifc.done === 1'b1) seen = 1'b1;
    end
    chk("mid_rst.no_done", {15'b0, seen}, 16'h0);
    rst_n = 1'b1;
    do_op("mul_post_rst", {1'b0, OP_MUL}, 8'hA5, 8'h5A, 0);

    for (int i = 0; i < 6; i++) begin
      do_op("rand", {1'b0, 1'($urandom)}, 8'($urandom), 8'($urandom_range(0, 255)), 0);
    end

`ifdef MULDIV_SIGNED_EN
    do_op("smul_m6x7",  2'b10, 8'hFA, 8'h07, 0);
    do_op("sdiv_m7_2",  2'b11, 8'hF9, 8'h02, 0);
    do_op("sdiv_50_m3", 2'b11, 8'd50, 8'hFD, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that borrows the CPU's shared 8-bit ALU to run unsigned 8x8 multiply (shift-add) and 8/8 divide (restoring).
- Sits beside the CPU control unit. While `busy`=1, the CPU datapath muxes `alu_a`/`alu_b`/`alu_mode`/`alu_cin` from this block into the ALU. Results are returned to the register file by the control unit on `done`.

Parameters:
- ITERS, 8, iteration count; equals the operand width; only 8 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only while busy=0
- op  in  2  op[0]: 0=MUL, 1=DIV; op[1]: signed (honoured only with macro, else ignored)
- a  in  8  multiplicand / dividend
- b  in  8  multiplier / divisor
- busy  out  1  sequencer owns the ALU
- done  out  1  one-cycle pulse, results valid
- res_hi  out  8  MUL: product[15:8]; DIV: remainder
- res_lo  out  8  MUL: product[7:0]; DIV: quotient
- dbz  out  1  divide-by-zero flag for the last DIV
- alu_a  out  8  ALU operand A
- alu_b  out  8  ALU operand B
- alu_mode  out  4  ALU mode
- alu_cin  out  1  ALU carry-in
- alu_out  in  8  ALU result
- alu_cout  in  1  ALU carry/borrow out

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, dbz=0; res_hi, res_lo=0; alu_a, alu_b=0; alu_mode=4'b1110 (pass A); alu_cin=0; all internal registers 0.
- States: IDLE → LOAD → ITER(x8) → DONE → IDLE.
  - With the macro: IDLE → PRE → LOAD → ITER → FIX → DONE.
- Start acceptance:
  - start=1 in IDLE at edge 0 latches op, a, b, clears dbz and sets busy.
  - start while busy=1 is ignored, with no queueing.
- Latency:
  - LOAD in cycle 1, ITER in cycles 2..9, DONE in cycle 10.
  - In DONE: done=1, busy=1, results updated at the edge that enters DONE.
  - busy falls at the edge that leaves DONE.
  - Earliest next start is sampled in the cycle after DONE.
- MUL:
  - LOAD sets P_hi=0, P_lo=b, M=a.
  - Each ITER drives alu_a=P_hi, alu_b=M.
    - If P_lo[0]=1: alu_mode=4'b0100 (ADD).
    - If P_lo[0]=0: alu_mode=4'b1110 (pass A) and the carry used is 0.
    - Then {carry,alu_out,P_lo} is shifted right by 1 into {P_hi,P_lo}.
- DIV:
  - LOAD sets R=0, Q=a, D=b.
  - Each ITER forms {r8,R'}={R,Q[7]} and drives alu_a=R', alu_b=D, alu_mode=4'b0111 (SUB), alu_cin=0.
  - Subtract succeeds when r8=1 or alu_cout=0. On success: R=alu_out, qbit=1. Otherwise R=R', qbit=0.
  - Q={Q[6:0],qbit}.
- Divide by zero: b=0 with DIV is detected in LOAD and skips to DONE in cycle 2. Results: res_lo=8'hFF, res_hi=a, dbz=1.
- ALU outputs: in IDLE and DONE, alu_* return to their reset values.
- Results: res_hi/res_lo hold until the next accepted start completes.
- Reset mid-operation aborts immediately to reset values, with no done pulse.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - op[1]=1 selects two's-complement operands.
  - PRE state (1 cycle) negates negative operands to magnitudes.
  - FIX state (1 cycle) negates the result:
    - MUL: 16-bit product if sign(a)^sign(b).
    - DIV: quotient if sign(a)^sign(b); remainder takes the sign of the dividend.
  - Signed latency is 12 cycles (DONE in cycle 12).
  - Signed DIV by 0: res_lo=8'hFF, res_hi=a, dbz=1.
  - op[1]=0 keeps the 10-cycle unsigned path.
- Undefined: op[1] is ignored; there are no PRE/FIX states.

Decomposition:
- Shared package/header `alu_defs`:
  - ALU mode constants (ADD 4'b0100, SUB 4'b0111, PASS_A 4'b1110).
  - OP_MUL/OP_DIV/OP_SIGNED bit positions.
  - State encoding.
- Natural sub-module `muldiv_sign_fix`: combinational conditional two's-complement negate of 8/16-bit values, instantiated only under MULDIV_SIGNED_EN.
- The ALU itself stays external.

Test Plan:
- MUL a=13, b=11 → done in cycle 10, res_hi=8'h00, res_lo=8'h8F, dbz=0, busy high cycles 1..10.
- MUL a=8'hFF, b=8'hFF → {res_hi,res_lo}=16'hFE01; check that the ADD carry is propagated into the shift.
- DIV a=200, b=7 → res_lo=8'h1C, res_hi=8'h04; DIV a=8'hFF, b=8'h01 → res_lo=8'hFF, res_hi=0 (r8 path).
- DIV a=8'h55, b=0 → done in cycle 2, res_lo=8'hFF, res_hi=8'h55, dbz=1; a following MUL clears dbz.
- start pulsed in cycle 5 of a MUL is ignored; rst_n low in cycle 6 gives all outputs at reset values with no done; new start after release completes normally.
- (MULDIV_SIGNED_EN) MUL op=2'b10, a=-6, b=7 → 16'hFFD6, done in cycle 12; DIV op=2'b11, a=-7, b=2 → res_lo=8'hFD, res_hi=8'hFF.
